// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache memory arbiter: default widths, FSM state
// encodings, read-owner IDs and the line-address compare used by the RAW guard.
package cache_arb_pkg;

  localparam int ADDR_W   = 32;   // byte address width
  localparam int DATA_W   = 32;   // refill beat width
  localparam int LINE_W   = 128;  // victim line width
  localparam int OFFSET_W = 4;    // line offset bits

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2
  } rd_state_e;

  typedef enum logic {
    W_EMPTY = 1'b0,
    W_FULL  = 1'b1
  } wr_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  // True when both byte addresses fall in the same cache line.
  function automatic logic same_line(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:OFFSET_W] == b[ADDR_W-1:OFFSET_W];
  endfunction

endpackage

// File: rtl/cache_arb_if.sv
// Bundle of every handshake/bus signal around the cache memory arbiter.
//   slave  : the arbiter's view (cache requests and memory responses in,
//            cache responses and memory requests out)
//   master : the surrounding caches + memory bridge view (directions flipped)
// Groups: ICache read/refill, DCache read/refill, DCache victim write,
//         memory read channel, memory write channel.
interface cache_arb_if #(
  parameter int ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int DATA_W = cache_arb_pkg::DATA_W,
  parameter int LINE_W = cache_arb_pkg::LINE_W
);
  logic              ic_rd_req;
  logic [ADDR_W-1:0] ic_rd_addr;
  logic              ic_rd_rdy;
  logic              ic_ret_valid;
  logic              ic_ret_last;
  logic [DATA_W-1:0] ic_ret_data;

  logic              dc_rd_req;
  logic [ADDR_W-1:0] dc_rd_addr;
  logic              dc_rd_rdy;
  logic              dc_ret_valid;
  logic              dc_ret_last;
  logic [DATA_W-1:0] dc_ret_data;

  logic              dc_wr_req;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [LINE_W-1:0] dc_wr_data;
  logic              dc_wr_rdy;

  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_rdy;
  logic              mem_ret_valid;
  logic              mem_ret_last;
  logic [DATA_W-1:0] mem_ret_data;

  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [LINE_W-1:0] mem_wr_data;
  logic              mem_wr_rdy;

  modport slave (
    input  ic_rd_req, ic_rd_addr, dc_rd_req, dc_rd_addr,
           dc_wr_req, dc_wr_addr, dc_wr_data,
           mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data, mem_wr_rdy,
    output ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
           dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data, dc_wr_rdy,
           mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data
  );

  modport master (
    output ic_rd_req, ic_rd_addr, dc_rd_req, dc_rd_addr,
           dc_wr_req, dc_wr_addr, dc_wr_data,
           mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data, mem_wr_rdy,
    input  ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
           dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data, dc_wr_rdy,
           mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/cache_arb_wbuf.sv
// One-entry DCache victim write buffer.
//   clk, rst                 : clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data   : victim line from the DCache; wr_rdy = buffer empty
//   mem_wr_req/addr/data     : line presented to memory while full
//   mem_wr_rdy               : memory takes the line this cycle
//   rd_addr/rd_hit           : RAW probe; rd_hit when full and rd_addr is in the
//                              buffered line
module cache_arb_wbuf
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int LINE_W = cache_arb_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  output logic              wr_rdy,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [LINE_W-1:0] mem_wr_data,
  input  logic              mem_wr_rdy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit
);

  wr_state_e         state;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] data_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= W_EMPTY;
    end else begin
      unique case (state)
        W_EMPTY: if (wr_req)     state <= W_FULL;
        W_FULL:  if (mem_wr_rdy) state <= W_EMPTY;
        default:                 state <= W_EMPTY;
      endcase
    end
  end

  // NOTE: the line register carries no reset; it is only observable while
  // W_FULL, and the outputs below are masked to zero otherwise.
  always_ff @(posedge clk) begin
    if (state == W_EMPTY && wr_req) begin
      addr_q <= wr_addr;
      data_q <= wr_data;
    end
  end

  assign wr_rdy      = (state == W_EMPTY);
  assign mem_wr_req  = (state == W_FULL);
  assign mem_wr_addr = mem_wr_req ? addr_q : '0;
  assign mem_wr_data = mem_wr_req ? data_q : '0;
  assign rd_hit      = mem_wr_req && same_line(rd_addr, addr_q);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory read channel between ICache and DCache refills (one
// outstanding read) and owns the DCache victim write buffer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cache_arb_if.slave -- cache-side read/refill/write handshakes
//              and memory-side read/write channels
// Build option: define CACHE_ARB_RR_EN to arbitrate simultaneous IC/DC
// requests with a 1-bit round-robin pointer; otherwise DC has fixed priority.
// A DC read whose line is still in the write buffer is held (RAW guard) and
// does not block an IC read.
module cache_mem_arbiter
  import cache_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  cache_arb_if.slave bus
);

  rd_state_e         rd_state;
  owner_e            owner_q;
  owner_e            winner;
  logic [ADDR_W-1:0] addr_q;
  logic              mem_rd_req_q;
  logic              wb_hit;
  logic              dc_ok;
  logic              rd_idle;
  logic              grant_ic;
  logic              grant_dc;
  logic              fwd;
`ifdef CACHE_ARB_RR_EN
  owner_e            rr_ptr;
`endif

  cache_arb_wbuf #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (bus.dc_wr_req),
    .wr_addr    (bus.dc_wr_addr),
    .wr_data    (bus.dc_wr_data),
    .wr_rdy     (bus.dc_wr_rdy),
    .mem_wr_req (bus.mem_wr_req),
    .mem_wr_addr(bus.mem_wr_addr),
    .mem_wr_data(bus.mem_wr_data),
    .mem_wr_rdy (bus.mem_wr_rdy),
    .rd_addr    (bus.dc_rd_addr),
    .rd_hit     (wb_hit)
  );

  // Arbitration: a RAW-gated DC request is treated as absent so IC can win.
  // NOTE: every always_comb output gets a value on every path (here all are
  // assigned unconditionally); a missed branch would infer a latch.
  always_comb begin
    rd_idle = (rd_state == R_IDLE) && !rst;
    dc_ok   = bus.dc_rd_req && !wb_hit;
`ifdef CACHE_ARB_RR_EN
    if (dc_ok && bus.ic_rd_req) winner = rr_ptr;
    else                        winner = dc_ok ? OWN_DC : OWN_IC;
`else
    winner = dc_ok ? OWN_DC : OWN_IC;
`endif
    grant_dc = rd_idle && dc_ok && (winner == OWN_DC);
    grant_ic = rd_idle && bus.ic_rd_req && (winner == OWN_IC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state     <= R_IDLE;
      owner_q      <= OWN_IC;
      addr_q       <= '0;
      mem_rd_req_q <= 1'b0;
`ifdef CACHE_ARB_RR_EN
      rr_ptr       <= OWN_DC;
`endif
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          if (grant_dc || grant_ic) begin
            rd_state     <= R_REQ;
            mem_rd_req_q <= 1'b1;
            owner_q      <= grant_dc ? OWN_DC : OWN_IC;
            addr_q       <= grant_dc ? bus.dc_rd_addr : bus.ic_rd_addr;
`ifdef CACHE_ARB_RR_EN
            rr_ptr       <= grant_dc ? OWN_IC : OWN_DC;
`endif
          end
        end
        R_REQ: begin
          if (bus.mem_rd_rdy) begin
            rd_state     <= R_WAIT;
            mem_rd_req_q <= 1'b0;
          end
        end
        R_WAIT: begin
          if (bus.mem_ret_valid && bus.mem_ret_last) rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign bus.ic_rd_rdy   = grant_ic;
  assign bus.dc_rd_rdy   = grant_dc;
  assign bus.mem_rd_req  = mem_rd_req_q;
  assign bus.mem_rd_addr = mem_rd_req_q ? addr_q : '0;

  // Refill beats pass straight through to the owner of the outstanding read.
  assign fwd              = (rd_state == R_WAIT) && !rst && bus.mem_ret_valid;
  assign bus.ic_ret_valid = fwd && (owner_q == OWN_IC);
  assign bus.ic_ret_last  = bus.ic_ret_valid && bus.mem_ret_last;
  assign bus.ic_ret_data  = bus.ic_ret_valid ? bus.mem_ret_data : '0;
  assign bus.dc_ret_valid = fwd && (owner_q == OWN_DC);
  assign bus.dc_ret_last  = bus.dc_ret_valid && bus.mem_ret_last;
  assign bus.dc_ret_data  = bus.dc_ret_valid ? bus.mem_ret_data : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed sequences, a table of
// idle-state arbitration vectors with a held victim line, and a randomized
// phase against a transaction-level reference model.
module tb_cache_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_arb_if bus ();
  cache_mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.ic_rd_req = 0; bus.ic_rd_addr = '0;
    bus.dc_rd_req = 0; bus.dc_rd_addr = '0;
    bus.dc_wr_req = 0; bus.dc_wr_addr = '0; bus.dc_wr_data = '0;
    bus.mem_rd_rdy = 0; bus.mem_ret_valid = 0; bus.mem_ret_last = 0;
    bus.mem_ret_data = '0; bus.mem_wr_rdy = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step(); step();
    rst = 1'b0;
  endtask

  // Every output except dc_wr_rdy and mem_wr_data, packed.
  function automatic logic [159:0] outs();
    return {bus.ic_rd_rdy, bus.ic_ret_valid, bus.ic_ret_last, bus.ic_ret_data,
            bus.dc_rd_rdy, bus.dc_ret_valid, bus.dc_ret_last, bus.dc_ret_data,
            bus.mem_rd_req, bus.mem_rd_addr, bus.mem_wr_req, bus.mem_wr_addr};
  endfunction

  // Called right after an accepting edge: checks the issued memory read,
  // waits dly cycles, hands over mem_rd_rdy, then returns 4 beats.
  task automatic serve_read(input bit own_dc, input logic [31:0] addr,
                            input int dly, input logic [31:0] seed);
    #1;
    check("rd_issue", {bus.mem_rd_req, bus.mem_rd_addr}, {1'b1, addr});
    for (int i = 0; i < dly; i++) begin
      step(); #1;
      check("rd_hold", {bus.mem_rd_req, bus.ic_rd_rdy, bus.dc_rd_rdy}, 3'b100);
    end
    bus.mem_rd_rdy = 1'b1;
    step();
    bus.mem_rd_rdy = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.mem_ret_valid = 1'b1;
      bus.mem_ret_last  = (b == 3);
      bus.mem_ret_data  = 32'(seed + 32'(b));
      #1;
      check("ret_route",
            {bus.mem_rd_req, bus.ic_ret_valid, bus.dc_ret_valid,
             own_dc ? bus.dc_ret_last : bus.ic_ret_last,
             own_dc ? bus.dc_ret_data : bus.ic_ret_data,
             bus.ic_rd_rdy, bus.dc_rd_rdy},
            {1'b0, !own_dc, own_dc, (b == 3), 32'(seed + 32'(b)), 2'b00});
      step();
    end
    bus.mem_ret_valid = 1'b0;
    bus.mem_ret_last  = 1'b0;
  endtask

  typedef struct {
    logic        ic_req;
    logic        dc_req;
    logic [31:0] dc_addr;
    logic [1:0]  exp_rdy;   // {ic_rd_rdy, dc_rd_rdy}
  } arb_vec_t;
  arb_vec_t vecs[7];

  // Reference model state for the random phase (transaction level).
  bit          m_busy, m_issued, m_dc, m_rr_dc;
  int          m_beats;
  logic [31:0] m_addr;
  bit          m_wb_full;
  logic [31:0] m_wb_addr;
  logic [127:0] m_wb_data;
  bit          hit, dc_ok, pick_dc, e_ic, e_dc, e_fwd;
  logic [31:0] addr_pool[6] = '{32'h2040, 32'h2048, 32'h204C, 32'h2050, 32'h3000, 32'h3008};

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 2'b10};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_3000, 2'b01};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_3000, 2'b01};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_2048, 2'b00};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_204C, 2'b10};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_2050, 2'b01};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_203C, 2'b01};

    // ---- reset state + test 1: IC-only read
    do_reset();
    #1;
    check("reset_outs", outs(), '0);
    check("reset_wr", {bus.dc_wr_rdy, bus.mem_wr_data}, {1'b1, 128'h0});
    bus.ic_rd_req = 1'b1; bus.ic_rd_addr = 32'h1000;
    #1;
    check("t1_ic_rdy", {bus.ic_rd_rdy, bus.dc_rd_rdy}, 2'b10);
    step();
    bus.ic_rd_req = 1'b0;
    serve_read(1'b0, 32'h1000, 2, 32'hA000_0000);
    #1;
    check("t1_idle", outs(), '0);

    // ---- test 2: contention
    do_reset();
    bus.ic_rd_req = 1'b1; bus.ic_rd_addr = 32'h1100;
    bus.dc_rd_req = 1'b1; bus.dc_rd_addr = 32'h5100;
    #1;
    check("t2_first_dc", {bus.ic_rd_rdy, bus.dc_rd_rdy}, 2'b01);
    step();
    bus.dc_rd_req = 1'b0;
    serve_read(1'b1, 32'h5100, 0, 32'hD000_0000);
`ifdef CACHE_ARB_RR_EN
    bus.dc_rd_req = 1'b1; bus.dc_rd_addr = 32'h5200;
`endif
    #1;
    check("t2_then_ic", {bus.ic_rd_rdy, bus.dc_rd_rdy}, 2'b10);
    step();
    bus.ic_rd_req = 1'b0;
    serve_read(1'b0, 32'h1100, 1, 32'hB000_0000);
`ifdef CACHE_ARB_RR_EN
    #1;
    check("t2_rr_dc", {bus.ic_rd_rdy, bus.dc_rd_rdy}, 2'b01);
    step();
    bus.dc_rd_req = 1'b0;
    serve_read(1'b1, 32'h5200, 0, 32'hD100_0000);
`endif

    // ---- test 3: held victim line, arbitration table, RAW release
    do_reset();
    bus.dc_wr_req = 1'b1; bus.dc_wr_addr = 32'h2040;
    bus.dc_wr_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    #1;
    check("t3_wr_rdy", bus.dc_wr_rdy, 1'b1);
    step();
    bus.dc_wr_req = 1'b0;
    #1;
    check("t3_wr_held", {bus.mem_wr_req, bus.mem_wr_addr, bus.dc_wr_rdy}, {1'b1, 32'h2040, 1'b0});
    for (int i = 0; i < 7; i++) begin
      bus.ic_rd_req = vecs[i].ic_req; bus.ic_rd_addr = 32'h4000;
      bus.dc_rd_req = vecs[i].dc_req; bus.dc_rd_addr = vecs[i].dc_addr;
      #1;
      check($sformatf("arb_vec%0d", i), {bus.ic_rd_rdy, bus.dc_rd_rdy}, vecs[i].exp_rdy);
      bus.ic_rd_req = 1'b0; bus.dc_rd_req = 1'b0;
      step();
    end
    bus.dc_rd_req = 1'b1; bus.dc_rd_addr = 32'h2048;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t3_gated", bus.dc_rd_rdy, 1'b0);
      step();
    end
    bus.dc_rd_addr = 32'h3000;
    #1;
    check("t3_other_line", bus.dc_rd_rdy, 1'b1);
    step();
    bus.dc_rd_req = 1'b0;
    serve_read(1'b1, 32'h3000, 0, 32'hC000_0000);
    bus.dc_rd_req = 1'b1; bus.dc_rd_addr = 32'h2048;
    bus.mem_wr_rdy = 1'b1;
    #1;
    check("t3_gate_wr_cycle", {bus.dc_rd_rdy, bus.mem_wr_req, bus.mem_wr_data},
          {1'b0, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888});
    step();
    bus.mem_wr_rdy = 1'b0;
    #1;
    check("t3_released", {bus.dc_rd_rdy, bus.dc_wr_rdy, bus.mem_wr_req}, 3'b110);
    step();
    bus.dc_rd_req = 1'b0;
    serve_read(1'b1, 32'h2048, 0, 32'hC100_0000);

    // ---- test 4: write and read active together
    bus.dc_wr_req = 1'b1; bus.dc_wr_addr = 32'h6000;
    bus.dc_wr_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D;
    bus.ic_rd_req = 1'b1; bus.ic_rd_addr = 32'h7000;
    #1;
    check("t4_accept_both", {bus.ic_rd_rdy, bus.dc_wr_rdy}, 2'b11);
    step();
    bus.dc_wr_req = 1'b0; bus.ic_rd_req = 1'b0;
    #1;
    check("t4_both_active", {bus.mem_wr_req, bus.mem_rd_req}, 2'b11);
    check("t4_wr_line", {bus.mem_wr_addr, bus.mem_wr_data},
          {32'h6000, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D});
    bus.mem_wr_rdy = 1'b1;
    serve_read(1'b0, 32'h7000, 0, 32'hE000_0000);
    bus.mem_wr_rdy = 1'b0;
    #1;
    check("t4_wr_done", {bus.dc_wr_rdy, bus.mem_wr_req}, 2'b10);

    // ---- test 5: reset in R_WAIT after beat 2
    step();
    bus.dc_wr_req = 1'b1; bus.dc_wr_addr = 32'h9000; bus.dc_wr_data = 128'h55;
    bus.ic_rd_req = 1'b1; bus.ic_rd_addr = 32'h1200;
    step();
    bus.dc_wr_req = 1'b0; bus.ic_rd_req = 1'b0;
    bus.mem_rd_rdy = 1'b1;
    step();
    bus.mem_rd_rdy = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.mem_ret_valid = 1'b1; bus.mem_ret_data = 32'(32'h77 + 32'(b));
      #1;
      check("t5_beat", {bus.ic_ret_valid, bus.ic_ret_data}, {1'b1, 32'(32'h77 + 32'(b))});
      step();
    end
    bus.mem_ret_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t5_reset_outs", outs(), '0);
    check("t5_reset_wr", {bus.dc_wr_rdy, bus.mem_wr_data}, {1'b1, 128'h0});
    bus.ic_rd_req = 1'b1; bus.ic_rd_addr = 32'h1300;
    #1;
    check("t5_fresh_rdy", bus.ic_rd_rdy, 1'b1);
    step();
    bus.ic_rd_req = 1'b0;
    serve_read(1'b0, 32'h1300, 0, 32'hF000_0000);

    // ---- test 6: back-to-back DC reads
    bus.dc_rd_req = 1'b1; bus.dc_rd_addr = 32'h8000;
    #1;
    check("t6_first", bus.dc_rd_rdy, 1'b1);
    step();
    bus.dc_rd_addr = 32'h8040;
    serve_read(1'b1, 32'h8000, 2, 32'h8800_0000);
    #1;
    check("t6_second", bus.dc_rd_rdy, 1'b1);
    step();
    bus.dc_rd_req = 1'b0;
    serve_read(1'b1, 32'h8040, 0, 32'h8900_0000);

    // ---- randomized phase against the reference model
    do_reset();
    m_busy = 0; m_issued = 0; m_dc = 0; m_rr_dc = 1; m_beats = 0; m_addr = '0;
    m_wb_full = 0; m_wb_addr = '0; m_wb_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.ic_rd_req     = 1'($urandom_range(0, 1));
      bus.ic_rd_addr    = addr_pool[$urandom_range(0, 5)];
      bus.dc_rd_req     = 1'($urandom_range(0, 1));
      bus.dc_rd_addr    = addr_pool[$urandom_range(0, 5)];
      bus.dc_wr_req     = ($urandom_range(0, 3) == 0);
      bus.dc_wr_addr    = addr_pool[$urandom_range(0, 5)];
      bus.dc_wr_data    = {$urandom, $urandom, $urandom, $urandom};
      bus.mem_rd_rdy    = 1'($urandom_range(0, 1));
      bus.mem_wr_rdy    = ($urandom_range(0, 3) == 0);
      bus.mem_ret_valid = m_busy && m_issued && ($urandom_range(0, 1) == 1);
      bus.mem_ret_last  = bus.mem_ret_valid && (m_beats == 3);
      bus.mem_ret_data  = $urandom;
      #1;
      hit   = m_wb_full && (bus.dc_rd_addr[31:4] == m_wb_addr[31:4]);
      dc_ok = bus.dc_rd_req && !hit;
`ifdef CACHE_ARB_RR_EN
      pick_dc = (dc_ok && bus.ic_rd_req) ? m_rr_dc : dc_ok;
`else
      pick_dc = dc_ok;
`endif
      e_dc  = !m_busy && dc_ok && pick_dc;
      e_ic  = !m_busy && bus.ic_rd_req && !pick_dc;
      e_fwd = m_busy && m_issued && bus.mem_ret_valid;
      check("rnd_ctrl",
            {bus.ic_rd_rdy, bus.dc_rd_rdy, bus.dc_wr_rdy, bus.mem_rd_req, bus.mem_wr_req,
             bus.ic_ret_valid, bus.ic_ret_last, bus.dc_ret_valid, bus.dc_ret_last},
            {e_ic, e_dc, !m_wb_full, m_busy && !m_issued, m_wb_full,
             e_fwd && !m_dc, e_fwd && !m_dc && bus.mem_ret_last,
             e_fwd && m_dc, e_fwd && m_dc && bus.mem_ret_last});
      check("rnd_rd_data",
            {bus.mem_rd_addr, bus.ic_ret_data, bus.dc_ret_data},
            {(m_busy && !m_issued) ? m_addr : 32'h0,
             (e_fwd && !m_dc) ? bus.mem_ret_data : 32'h0,
             (e_fwd && m_dc) ? bus.mem_ret_data : 32'h0});
      check("rnd_wr_line", {bus.mem_wr_addr, bus.mem_wr_data},
            m_wb_full ? {m_wb_addr, m_wb_data} : 160'h0);
      // advance the model across the coming edge
      if (e_dc || e_ic) begin
        m_busy = 1; m_issued = 0; m_beats = 0; m_dc = e_dc;
        m_addr = e_dc ? bus.dc_rd_addr : bus.ic_rd_addr;
        m_rr_dc = !e_dc;
      end else if (m_busy && !m_issued && bus.mem_rd_rdy) begin
        m_issued = 1;
      end else if (e_fwd) begin
        if (bus.mem_ret_last) m_busy = 0;
        else m_beats++;
      end
      if (m_wb_full && bus.mem_wr_rdy) begin
        m_wb_full = 0;
      end else if (!m_wb_full && bus.dc_wr_req) begin
        m_wb_full = 1; m_wb_addr = bus.dc_wr_addr; m_wb_data = bus.dc_wr_data;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
